spi_xfer_ctrl: RTL

Transfer sequencer for the SPI master. It accepts a start request with a frame length and drives chip select and transfer-in-progress into the SPI clock generator, with optional CS setup and hold delays. It counts the generator's shift/sample pulses to detect the end of the frame, returns the clock to idle, and reports completion. It sits between the register/host interface and `spi_clkgen`.

---
 rtl/spi_xfer_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/spi_xfer_ctrl.sv
// SPI transfer sequencer: frames cs_n/tip around the clkgen edge pulses.
// Optional CS setup/hold delay states are built when SPI_CS_DELAY_EN is defined.
module spi_xfer_ctrl #(
  parameter int LEN_WIDTH = 7,
  parameter int DLY_WIDTH = 8
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [LEN_WIDTH-1:0] char_len,
  input  logic [DLY_WIDTH-1:0] cs_setup,
  input  logic [DLY_WIDTH-1:0] cs_hold,
  input  logic                 shift_i,
  input  logic                 sample_i,
  output logic                 tip,
  output logic                 cs_n,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic [LEN_WIDTH:0]   bit_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_XFER  = 2'd2;
`ifdef SPI_CS_DELAY_EN
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd3;
`endif

  logic [1:0]           state;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH+1:0] edge_cnt;
  logic [LEN_WIDTH+1:0] edge_nxt;
  logic [LEN_WIDTH+1:0] target;
  logic [LEN_WIDTH:0]   frame_len;
  logic                 edge_p;
  logic                 last_edge;

  // Length 0 means a full 2^LEN_WIDTH-bit frame; two clock edges per bit.
  assign frame_len = (len_q == '0) ? {1'b1, {LEN_WIDTH{1'b0}}}
                                   : {1'b0, len_q};
  assign target    = {frame_len, 1'b0};
  assign edge_p    = shift_i | sample_i;
  assign edge_nxt  = edge_cnt + 1'b1;
  assign last_edge = edge_p && (edge_nxt == target);

`ifdef SPI_CS_DELAY_EN
  logic [DLY_WIDTH-1:0] setup_q;
  logic [DLY_WIDTH-1:0] hold_q;
  logic [DLY_WIDTH-1:0] dly_cnt;
  logic [DLY_WIDTH-1:0] dly_nxt;

  assign dly_nxt = dly_cnt + 1'b1;
`else
  logic unused_dly;

  assign unused_dly = ^{cs_setup, cs_hold};
`endif

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      tip      <= 1'b0;
      cs_n     <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
      bit_cnt  <= '0;
      edge_cnt <= '0;
      len_q    <= '0;
`ifdef SPI_CS_DELAY_EN
      setup_q  <= '0;
      hold_q   <= '0;
      dly_cnt  <= '0;
`endif
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start && !abort) begin
            len_q    <= char_len;
            bit_cnt  <= '0;
            edge_cnt <= '0;
            cs_n     <= 1'b0;
            busy     <= 1'b1;
`ifdef SPI_CS_DELAY_EN
            setup_q  <= cs_setup;
            hold_q   <= cs_hold;
            dly_cnt  <= '0;
            if (cs_setup != '0) begin
              state <= S_SETUP;
            end else begin
              tip   <= 1'b1;
              state <= S_XFER;
            end
`else
            tip      <= 1'b1;
            state    <= S_XFER;
`endif
          end
        end
`ifdef SPI_CS_DELAY_EN
        S_SETUP: begin
          dly_cnt <= dly_nxt;
          if (abort) begin
            cs_n    <= 1'b1;
            busy    <= 1'b0;
            aborted <= 1'b1;
            state   <= S_IDLE;
          end else if (dly_nxt == setup_q) begin
            tip   <= 1'b1;
            state <= S_XFER;
          end
        end
`endif
        S_XFER: begin
          if (abort) begin
            tip     <= 1'b0;
            cs_n    <= 1'b1;
            busy    <= 1'b0;
            aborted <= 1'b1;
            state   <= S_IDLE;
          end else begin
            if (edge_p) edge_cnt <= edge_nxt;
            if (sample_i) bit_cnt <= bit_cnt + 1'b1;
            if (last_edge) begin
              tip <= 1'b0;
`ifdef SPI_CS_DELAY_EN
              dly_cnt <= '0;
              if (hold_q != '0) begin
                state <= S_HOLD;
              end else begin
                cs_n  <= 1'b1;
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= S_IDLE;
              end
`else
              cs_n  <= 1'b1;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_IDLE;
`endif
            end
          end
        end
`ifdef SPI_CS_DELAY_EN
        S_HOLD: begin
          dly_cnt <= dly_nxt;
          if (abort) begin
            cs_n    <= 1'b1;
            busy    <= 1'b0;
            aborted <= 1'b1;
            state   <= S_IDLE;
          end else if (dly_nxt == hold_q) begin
            cs_n  <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_IDLE;
          end
        end
`endif
        default: begin
          tip   <= 1'b0;
          cs_n  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
